// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: funct3 size codes, FSM states, default depth.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam int DEPTH_BYTES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering within one doubleword: load extraction/extension, store byte enables,
// and detection of misaligned or illegal-size accesses. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] dword,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_data,
  output logic [7:0]  byte_en,
  output logic        err
);

  logic [63:0] shifted;
  logic [7:0]  size_mask;
  logic        misalign;
  logic        illegal;

  always_comb begin
    shifted    = dword >> {addr_lo, 3'b000};
    store_data = wdata << {addr_lo, 3'b000};

    case (funct3[1:0])
      2'b00:   begin misalign = 1'b0;          size_mask = 8'h01; end
      2'b01:   begin misalign = addr_lo[0];    size_mask = 8'h03; end
      2'b10:   begin misalign = |addr_lo[1:0]; size_mask = 8'h0f; end
      default: begin misalign = |addr_lo;      size_mask = 8'hff; end
    endcase

    // Stores only have four sizes; loads lose just the 111 code.
    illegal = write ? funct3[2] : (funct3 == 3'b111);
    err     = misalign | illegal;
    byte_en = err ? 8'h00 : (size_mask << addr_lo);

    case (funct3)
      F3_B:    load_data = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    load_data = shifted;
      F3_BU:   load_data = {56'd0, shifted[7:0]};
      F3_HU:   load_data = {48'd0, shifted[15:0]};
      F3_WU:   load_data = {32'd0, shifted[31:0]};
      default: load_data = 64'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle MEM-stage data memory: one request in flight, fixed latency, single-cycle response pulse.
// The store write and the response registers both update on the edge that leaves RESP, so a reset in RESP aborts cleanly.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = DEPTH_BYTES_DEFAULT,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  state_t           state;
  logic [3:0]       cnt;
  logic             cap_write;
  logic [IDX_W-1:0] cap_addr;
  logic [63:0]      cap_wdata;
  logic [2:0]       cap_funct3;

  logic [7:0]  mem [DEPTH_BYTES];
  logic [63:0] dword;
  logic [63:0] load_data;
  logic [63:0] store_data;
  logic [7:0]  byte_en;
  logic        err;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[ADDR_W-1:IDX_W];

  always_comb begin
    dword = 64'd0;
    for (int i = 0; i < 8; i++)
      dword[8*i +: 8] = mem[{cap_addr[IDX_W-1:3], 3'(i)}];
  end

  mem_lane_align u_lane (
    .write      (cap_write),
    .funct3     (cap_funct3),
    .addr_lo    (cap_addr[2:0]),
    .dword      (dword),
    .wdata      (cap_wdata),
    .load_data  (load_data),
    .store_data (store_data),
    .byte_en    (byte_en),
    .err        (err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 64'd0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= 64'd0;
      cap_funct3 <= 3'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write  <= req_write;
            cap_addr   <= req_addr[IDX_W-1:0];
            cap_wdata  <= req_wdata;
            cap_funct3 <= req_funct3;
            busy       <= 1'b1;
            req_ready  <= 1'b0;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) state <= RESP;
          cnt <= cnt - 4'd1;
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (cap_write || err) ? 64'd0 : load_data;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          cnt       <= 4'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backing array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && cap_write) begin
      for (int i = 0; i < 8; i++)
        if (byte_en[i]) mem[{cap_addr[IDX_W-1:3], 3'(i)}] <= store_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder at LATENCY=2, DEPTH_BYTES=1024.
module tb_data_mem_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  logic prev_rv = 1'b0;

  data_mem_responder #(.DEPTH_BYTES(1024), .LATENCY(LAT), .ADDR_W(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response monitor: pops the scoreboard and checks data, error flag, latency and pulse width.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      chk("pulse_one_cycle", {63'd0, prev_rv}, 64'd0);
      chk("rsp_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
        chk("rsp_latency", 64'(cyc - a), 64'(LAT));
      end
    end
    prev_rv <= rsp_valid && !reset;
  end

  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [2:0] f, input logic [63:0] er, input logic ee);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f;
    e.rdata = er;
    e.err   = ee;
    exp_q.push_back(e);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  localparam logic [63:0] V1 = 64'h1122334455667788;
  localparam logic [63:0] V2 = 64'h0123456789abcdef;

  initial begin
    logic [63:0] good_addr [3];
    logic [2:0]  good_f3   [3];
    logic [63:0] good_exp  [3];
    int issued;
    int prev_acc;
    int n;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err",   {63'd0, rsp_err}, 64'd0);
    chk("rst_busy",      {63'd0, busy}, 64'd0);

    // Basic store/load round trip, plus busy seen mid-request.
    issue(1'b1, 64'h10, V1, 3'b011, 64'd0, 1'b0);
    chk("busy_mid", {63'd0, busy}, 64'd1);
    issue(1'b0, 64'h10, 64'd0, 3'b011, V1, 1'b0);
    drain();

    // Sized loads with sign/zero extension.
    issue(1'b0, 64'h10, 64'd0, 3'b000, 64'hFFFFFFFFFFFFFF88, 1'b0);
    issue(1'b0, 64'h10, 64'd0, 3'b100, 64'h88, 1'b0);
    issue(1'b0, 64'h16, 64'd0, 3'b001, 64'h1122, 1'b0);
    issue(1'b0, 64'h14, 64'd0, 3'b110, 64'h11223344, 1'b0);
    drain();

    // Partial stores touch only their own bytes.
    issue(1'b1, 64'h18, 64'd0, 3'b011, 64'd0, 1'b0);
    issue(1'b1, 64'h18, 64'hCAFEF00DDEADBEEF, 3'b010, 64'd0, 1'b0);
    issue(1'b0, 64'h18, 64'd0, 3'b011, 64'h00000000DEADBEEF, 1'b0);
    issue(1'b1, 64'h1B, 64'h77665544332211AA, 3'b000, 64'd0, 1'b0);
    issue(1'b0, 64'h18, 64'd0, 3'b010, 64'hFFFFFFFFAAADBEEF, 1'b0);
    drain();

    // Misaligned load, illegal store size, misaligned store; memory untouched.
    issue(1'b0, 64'h12, 64'd0, 3'b010, 64'd0, 1'b1);
    issue(1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 3'b100, 64'd0, 1'b1);
    issue(1'b1, 64'h11, 64'hFFFFFFFFFFFFFFFF, 3'b001, 64'd0, 1'b1);
    issue(1'b0, 64'h10, 64'd0, 3'b111, 64'd0, 1'b1);
    issue(1'b0, 64'h10, 64'd0, 3'b011, V1, 1'b0);
    drain();

    // Valid held high; inputs scrambled into a store while busy must be ignored.
    good_addr = '{64'h10, 64'h10, 64'h14};
    good_f3   = '{3'b011, 3'b100, 3'b110};
    good_exp  = '{V1, 64'h88, 64'h11223344};
    issued = 0;
    prev_acc = 0;
    n = 0;
    while (issued < 3 && n < 40) begin
      @(negedge clk);
      n++;
      req_valid = 1'b1;
      if (req_ready) begin
        exp_t e;
        req_write  = 1'b0;
        req_addr   = good_addr[issued];
        req_wdata  = 64'd0;
        req_funct3 = good_f3[issued];
        e.rdata = good_exp[issued];
        e.err   = 1'b0;
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
        if (issued > 0) chk("accept_spacing", 64'(cyc + 1 - prev_acc), 64'(LAT + 1));
        prev_acc = cyc + 1;
        issued++;
      end else begin
        req_write  = 1'b1;
        req_addr   = 64'h10;
        req_wdata  = 64'hFFFFFFFFFFFFFFFF;
        req_funct3 = 3'b011;
      end
    end
    chk("stream_issued", 64'(issued), 64'd3);
    @(negedge clk);
    chk("ready_low_after_accept", {63'd0, req_ready}, 64'd0);
    req_valid = 1'b0;
    drain();
    issue(1'b0, 64'h10, 64'd0, 3'b011, V1, 1'b0);
    drain();

    // Reset during WAIT aborts a store with no response.
    issue(1'b1, 64'h20, V2, 3'b011, 64'd0, 1'b0);
    drain();
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 64'h20;
    req_wdata  = 64'hFFFFFFFFFFFFFFFF;
    req_funct3 = 3'b011;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_wait", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    repeat (4) @(negedge clk);
    issue(1'b0, 64'h20, 64'd0, 3'b011, V2, 1'b0);

    // Address bits above the array index are ignored.
    issue(1'b0, 64'h410, 64'd0, 3'b011, V1, 1'b0);
    issue(1'b0, 64'hFFFF000000000010, 64'd0, 3'b011, V1, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
